mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle unsigned multiply/divide sequencer for the single-cycle CPU. It computes MULTU and DIVU results into HI/LO by iterating 32 times over the shared 32-bit ALU. On each iteration it drives the ALU's A/B/ALUOp inputs and consumes its C output. It sits beside the register file, is started by the decoder, and stalls the pipeline through `busy` until `done`.

## Interface
Parameters:
- none; width fixed at 32, iteration count fixed at 32.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only while idle (`busy`=0).
- `op`  in  2  operation select: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
- `rs_val`  in  32  multiplier / dividend / MTHI-MTLO source.
- `rt_val`  in  32  multiplicand / divisor.
- `alu_req`  out  1  high in every MUL/DIV state cycle; requests the shared ALU.
- `alu_gnt`  in  1  ALU granted this cycle; when low the iteration does not advance.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_op`  out  5  ALU opcode, using the `ALU_*` codes from ctrl_encode_def.v.
- `alu_c`  in  32  ALU result, combinational in the same cycle.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle registered completion pulse.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- **FSM states:** IDLE, MUL, DIV. There is a 5-bit iteration counter `cnt`, plus a latched operand register `opnd` that holds `rt_val` at start.
- **IDLE, on `start`:**
  - MULTU: hi←0, lo←rs_val, opnd←rt_val, cnt←0, go to MUL.
  - DIVU: hi←0, lo←rs_val, opnd←rt_val, cnt←0, go to DIV.
  - MTHI: hi←rs_val, stay in IDLE, done←1.
  - MTLO: lo←rs_val, stay in IDLE, done←1.
- **MUL iteration** (only on edges with alu_gnt=1):
  - alu_op=`ALU_ADD`, alu_a=hi, alu_b=opnd.
  - If lo[0]=1: sum=alu_c, carry=(alu_c < hi), unsigned compare done locally.
  - Else: sum=hi, carry=0.
  - Update {hi,lo}←{carry,sum,lo[31:1]}.
- **DIV iteration** (only on edges with alu_gnt=1):
  - Form {msb,sh_hi,sh_lo}={hi,lo}<<1.
  - alu_op=`ALU_SUB`, alu_a=sh_hi, alu_b=opnd.
  - borrow=(sh_hi < opnd), unsigned.
  - If msb=1 or borrow=0: hi←alu_c, lo←{sh_lo[31:1],1}.
  - Else: hi←sh_hi, lo←{sh_lo[31:1],0}.
- **Completion:** on the iteration edge with cnt=31, write the final hi/lo, set done←1, return to IDLE. Otherwise cnt←cnt+1.
- **Results:**
  - MULTU: {hi,lo} = 64-bit product.
  - DIVU: lo=quotient, hi=remainder.
- **Divide by zero:** no special case. The algorithm yields lo=0xFFFFFFFF and hi=dividend.
- **ALU outputs outside MUL/DIV:** alu_op=`ALU_NOP`, alu_a=0, alu_b=0, alu_req=0.
- **ALU outputs in MUL/DIV:** driven every cycle regardless of alu_gnt.
- **Start while busy:** ignored, with no effect on state, operands or counter.
- **Reset:**
  - State IDLE, cnt=0, hi=0, lo=0, opnd=0, done=0.
  - busy=0 and alu_req=0 follow from IDLE.
  - Reset mid-operation aborts it with no done pulse.

## Timing
- busy = alu_req = (state≠IDLE); both are combinational from the state register.
- done is registered: high exactly one cycle after the completing edge, otherwise 0.
- MULTU/DIVU with alu_gnt held at 1:
  - start sampled at edge E0; iterations at edges E1..E32.
  - busy is high for the 32 cycles between E0 and E32.
  - done and final hi/lo are visible in the cycle after E32, i.e. 33 cycles after start.
- Each cycle with alu_gnt=0 in MUL/DIV adds one cycle of latency; hi, lo and cnt hold.
- MTHI/MTLO: register updated at E0, done high in the following cycle, busy never asserted.
- A new start is accepted in the same cycle that done is high (the FSM is already IDLE).
- hi/lo change only on the edges listed above; intermediate values are visible during MUL/DIV and are not architecturally valid until done.

## Test plan
- **MULTU 3×5** (rs=3, rt=5, gnt=1): → done at cycle 33, hi=0x00000000, lo=0x0000000F, busy high for exactly 32 cycles.
- **MULTU 0xFFFFFFFF×0xFFFFFFFF:** → hi=0xFFFFFFFE, lo=0x00000001. This exercises carry out of every add.
- **DIVU 100/7:** → lo=14, hi=2.
- **DIVU 0x80000000/3:** → lo=0x2AAAAAAA, hi=2.
- **DIVU 0x1234/0:** → lo=0xFFFFFFFF, hi=0x00001234.
- **MULTU 3×5 with alu_gnt=0 for 5 cycles from cycle 10:**
  - done at cycle 38, result unchanged.
  - A second start during busy is ignored.
- **Reset and MTHI:**
  - Assert rst at cycle 12 of a DIVU → next cycle hi=lo=0, busy=0, no done pulse.
  - Then MTHI rs=0xDEADBEEF → hi=0xDEADBEEF with done one cycle later, busy stays 0.
  - Then MTLO rs=0x5 → lo=0x5.

Source files
------------

// File: rtl/mdu_seq_if.sv
// mdu_seq_if: decoder/ALU-side bundle of the multiply/divide sequencer
interface mdu_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        alu_req;
   logic        alu_gnt;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_op;
   logic [31:0] alu_c;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (
      output start, op, rs_val, rt_val, alu_gnt, alu_c,
      input  alu_req, alu_a, alu_b, alu_op, busy, done, hi, lo
   );
   modport slave (
      input  start, op, rs_val, rt_val, alu_gnt, alu_c,
      output alu_req, alu_a, alu_b, alu_op, busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: 32-iteration MULTU/DIVU sequencer over the shared ALU, plus MTHI/MTLO
module mdu_seq (
   input logic      clk,
   input logic      rst,
   mdu_seq_if.slave bus
);
   localparam logic [4:0] ALU_NOP = 5'd0;
   localparam logic [4:0] ALU_ADD = 5'd1;
   localparam logic [4:0] ALU_SUB = 5'd2;
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_opnd;
   logic        r_done;
   logic [31:0] w_hi, w_lo, w_sh_hi, w_sum;
   logic        w_carry, w_borrow, w_fit, w_step, w_last, w_done, w_load;
   always_comb begin
      w_sh_hi     = {r_hi[30:0], r_lo[31]};
      w_borrow    = w_sh_hi < r_opnd;
      w_fit       = r_hi[31] | ~w_borrow;
      w_sum       = r_lo[0] ? bus.alu_c : r_hi;
      // carry out of the ALU add is recovered by wrap-around detection
      w_carry     = r_lo[0] & (bus.alu_c < r_hi);
      w_step      = (r_state != IDLE) & bus.alu_gnt;
      w_last      = w_step & (r_cnt == 5'd31);
      w_load      = (r_state == IDLE) & bus.start;
      bus.alu_op  = r_state == MUL ? ALU_ADD : r_state == DIV ? ALU_SUB : ALU_NOP;
      bus.alu_a   = r_state == MUL ? r_hi : r_state == DIV ? w_sh_hi : 32'd0;
      bus.alu_b   = r_state == IDLE ? 32'd0 : r_opnd;
      bus.busy    = r_state != IDLE;
      bus.alu_req = r_state != IDLE;
      bus.done    = r_done;
      bus.hi      = r_hi;
      bus.lo      = r_lo;
      w_next      = r_state;
      w_hi        = r_hi;
      w_lo        = r_lo;
      w_done      = w_last;
      if (w_load) begin
         w_next = bus.op == 2'b00 ? MUL : bus.op == 2'b01 ? DIV : IDLE;
         w_hi   = bus.op == 2'b10 ? bus.rs_val : bus.op == 2'b11 ? r_hi : 32'd0;
         w_lo   = bus.op == 2'b10 ? r_lo : bus.rs_val;
         w_done = bus.op[1];
      end else if (w_step) begin
         w_next = w_last ? IDLE : r_state;
         w_hi   = r_state == MUL ? {w_carry, w_sum[31:1]} : w_fit ? bus.alu_c : w_sh_hi;
         w_lo   = r_state == MUL ? {w_sum[0], r_lo[31:1]} : {r_lo[30:0], w_fit};
      end
   end
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= 5'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_opnd <= 32'd0;
         r_done <= 1'b0;
      end else begin
         r_hi   <= w_hi;
         r_lo   <= w_lo;
         r_done <= w_done;
         if (w_load && !bus.op[1]) begin
            r_opnd <= bus.rt_val;
            r_cnt  <= 5'd0;
         end else if (w_step) begin
            r_cnt  <= r_cnt + 5'd1;
         end
      end
   end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors with a done-driven scoreboard for mdu_seq
module tb_mdu_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb[$];
   logic [63:0] exp_q;
   always #5 clk = ~clk;
   mdu_seq_if bus();
   mdu_seq u_dut (.clk(clk), .rst(rst), .bus(bus));
   assign bus.alu_c = bus.alu_op == 5'd1 ? bus.alu_a + bus.alu_b :
                      bus.alu_op == 5'd2 ? bus.alu_a - bus.alu_b : 32'd0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got hi=%h lo=%h with nothing expected", bus.hi, bus.lo);
         end else begin
            exp_q = sb.pop_front();
            chk("hilo", {bus.hi, bus.lo}, exp_q);
         end
      end
   end
   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] e, input int exp_cyc, input int stall_at, input int restart_at);
      int cyc = 0;
      int nb = 0;
      sb.push_back(e);
      bus.start  = 1'b1;
      bus.op     = o;
      bus.rs_val = a;
      bus.rt_val = b;
      do begin
         @(negedge clk);
         cyc++;
         bus.start   = cyc == restart_at;
         bus.alu_gnt = !(cyc >= stall_at && cyc < stall_at + 5);
         if (cyc == restart_at) begin
            bus.op     = 2'b01;
            bus.rs_val = 32'd99;
            bus.rt_val = 32'd1;
         end
         if (bus.busy) nb++;
         if (cyc == 1 && !o[1]) begin
            chk({nm, "_alu_req"}, 64'(bus.alu_req), 64'd1);
            chk({nm, "_alu_op"}, 64'(bus.alu_op), o == 2'b00 ? 64'd1 : 64'd2);
            chk({nm, "_alu_a"}, 64'(bus.alu_a), o == 2'b00 ? 64'd0 : 64'(a[31]));
            chk({nm, "_alu_b"}, 64'(bus.alu_b), 64'(b));
         end
      end while (!bus.done && cyc < 100);
      bus.start = 1'b0;
      chk({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      chk({nm, "_busy"}, 64'(nb), o[1] ? 64'd0 : 64'(exp_cyc - 1));
   endtask
   initial begin
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_val  = 32'd0;
      bus.rt_val  = 32'd0;
      bus.alu_gnt = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rst_flags", {60'd0, bus.busy, bus.done, bus.alu_req, 1'b0}, 64'd0);
      chk("rst_alu", {bus.alu_a, bus.alu_b[26:0], bus.alu_op}, 64'd0);
      rst = 1'b0;
      run("mul_3x5",    2'b00, 32'd3,         32'd5,          {32'h0, 32'hF},                33, 1000, 0);
      run("mul_ffxff",  2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,   {32'hFFFFFFFE, 32'h1},         33, 1000, 0);
      run("mul_64k",    2'b00, 32'h10000,     32'h10000,      {32'h1, 32'h0},                33, 1000, 0);
      run("div_100_7",  2'b01, 32'd100,       32'd7,          {32'd2, 32'd14},               33, 1000, 0);
      run("div_big_3",  2'b01, 32'h80000000,  32'd3,          {32'd2, 32'h2AAAAAAA},         33, 1000, 0);
      run("div_7_100",  2'b01, 32'd7,         32'd100,        {32'd7, 32'd0},                33, 1000, 0);
      run("div_ff_1",   2'b01, 32'hFFFFFFFF,  32'd1,          {32'd0, 32'hFFFFFFFF},         33, 1000, 0);
      run("div_by0",    2'b01, 32'h1234,      32'd0,          {32'h1234, 32'hFFFFFFFF},      33, 1000, 0);
      run("mul_stall",  2'b00, 32'd3,         32'd5,          {32'h0, 32'hF},                38, 10, 20);
      bus.start  = 1'b1;
      bus.op     = 2'b01;
      bus.rs_val = 32'd1000;
      bus.rt_val = 32'd3;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("abort_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_no_done", 64'(bus.done), 64'd0);
      run("mthi", 2'b10, 32'hDEADBEEF, 32'd0, {32'hDEADBEEF, 32'd0}, 1, 1000, 0);
      run("mtlo", 2'b11, 32'd5,        32'd0, {32'hDEADBEEF, 32'd5}, 1, 1000, 0);
      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
